// File: rtl/rob_pkg.sv
// Shared types and default widths for the reorder buffer ring.
package rob_pkg;

  localparam int unsigned ROB_XLEN  = 32;
  localparam int unsigned ROB_REG_W = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } rob_state_e;

  typedef struct packed {
    rob_state_e                 state;
    logic [ROB_REG_W-1:0]       dest;
    logic                       wb;
    logic [ROB_XLEN-1:0]        value;
  } rob_entry_t;

endpackage

// File: rtl/rob_slot.sv
// One reorder-buffer entry: IDLE -> WAIT on alloc, WAIT -> DONE on capture, back to IDLE on commit.
module rob_slot
  import rob_pkg::*;
#(
  parameter int unsigned XLEN  = ROB_XLEN,
  parameter int unsigned REG_W = ROB_REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_en,
  input  logic [REG_W-1:0] alloc_dest,
  input  logic             alloc_wb,
  input  logic             capture_en,
  input  logic [XLEN-1:0]  capture_value,
  input  logic             commit_en,
  output rob_state_e       state,
  output logic [REG_W-1:0] dest,
  output logic             wb,
  output logic [XLEN-1:0]  value
);

  rob_state_e       state_q, state_d;
  logic [REG_W-1:0] dest_q, dest_d;
  logic             wb_q, wb_d;
  logic [XLEN-1:0]  value_q, value_d;

  // Commit wins over capture so a bypassed WAIT entry drops straight to IDLE.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    wb_d    = wb_q;
    value_d = value_q;
    if (alloc_en) begin
      state_d = StWait;
      dest_d  = alloc_dest;
      wb_d    = alloc_wb;
      value_d = '0;
    end else if (commit_en) begin
      state_d = StIdle;
    end else if (capture_en && state_q == StWait) begin
      state_d = StDone;
      value_d = capture_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state_q <= StIdle;
      dest_q  <= '0;
      wb_q    <= 1'b0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      wb_q    <= wb_d;
      value_q <= value_d;
    end
  end

  assign state = state_q;
  assign dest  = dest_q;
  assign wb    = wb_q;
  assign value = value_q;

endmodule

// File: rtl/reorder_buffer_ring.sv
// Circular reorder buffer: in-order alloc, tag-addressed CDB capture, in-order retire.
// Define ROB_CDB_BYPASS_EN to let a CDB result for the WAIT head retire in the same cycle.
module reorder_buffer_ring
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = ROB_XLEN,
  parameter int unsigned REG_W = ROB_REG_W,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [REG_W-1:0] alloc_dest,
  input  logic             alloc_wb,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  output logic             commit_valid,
  output logic             commit_wen,
  output logic [REG_W-1:0] commit_dest,
  output logic [XLEN-1:0]  commit_value,
  input  logic             flush,
  output logic [TAG_W:0]   count,
  output logic             empty
);

  localparam logic [TAG_W:0] FullCount = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  rob_state_e       slot_state [DEPTH];
  logic [REG_W-1:0] slot_dest  [DEPTH];
  logic             slot_wb    [DEPTH];
  logic [XLEN-1:0]  slot_value [DEPTH];

  rob_state_e       head_state;
  logic             alloc_fire;
  logic             commit_fire;

  assign alloc_ready = (count_q != FullCount);
  assign alloc_tag   = tail_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign head_state  = slot_state[head_q];

  // alloc_ready is registered-only, so a full ring never reuses the slot freed this cycle.
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
  assign commit_fire = commit_valid;

  always_comb begin
    commit_valid = 1'b0;
    commit_value = slot_value[head_q];
    if (!flush) begin
      if (head_state == StDone) begin
        commit_valid = 1'b1;
`ifdef ROB_CDB_BYPASS_EN
      end else if (cdb_valid && cdb_tag == head_q && head_state == StWait) begin
        commit_valid = 1'b1;
        commit_value = cdb_value;
`endif
      end
    end
    commit_wen  = commit_valid & slot_wb[head_q];
    commit_dest = slot_dest[head_q];
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (commit_fire) head_d = head_q + TAG_W'(1);
    if (alloc_fire)  tail_d = tail_q + TAG_W'(1);
    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + (TAG_W+1)'(1);
      2'b01:   count_d = count_q - (TAG_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rob_slot #(
      .XLEN  (XLEN),
      .REG_W (REG_W)
    ) u_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .alloc_en      (alloc_fire && tail_q == TAG_W'(i)),
      .alloc_dest    (alloc_dest),
      .alloc_wb      (alloc_wb),
      .capture_en    (cdb_valid && cdb_tag == TAG_W'(i)),
      .capture_value (cdb_value),
      .commit_en     (commit_fire && head_q == TAG_W'(i)),
      .state         (slot_state[i]),
      .dest          (slot_dest[i]),
      .wb            (slot_wb[i]),
      .value         (slot_value[i])
    );
  end

endmodule

// File: tb/tb_reorder_buffer_ring.sv
// Directed bench for reorder_buffer_ring with an in-order queue model checked every cycle.
module tb_reorder_buffer_ring;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int TAG_W = 3;
`ifdef ROB_CDB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [REG_W-1:0] alloc_dest;
  logic             alloc_wb;
  logic [TAG_W-1:0] alloc_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             commit_valid;
  logic             commit_wen;
  logic [REG_W-1:0] commit_dest;
  logic [XLEN-1:0]  commit_value;
  logic             flush;
  logic [TAG_W:0]   count;
  logic             empty;

  always #5 clk = ~clk;

  reorder_buffer_ring #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .REG_W (REG_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_dest   (alloc_dest),
    .alloc_wb     (alloc_wb),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .commit_valid (commit_valid),
    .commit_wen   (commit_wen),
    .commit_dest  (commit_dest),
    .commit_value (commit_value),
    .flush        (flush),
    .count        (count),
    .empty        (empty)
  );

  typedef struct {
    int          tag;
    int          dest;
    bit          wb;
    bit          done;
    logic [31:0] value;
  } ent_t;

  ent_t q[$];
  int   tail_m = 0;
  int   total  = 0;
  int   bad    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Oldest in-flight instruction retires when it has a result (or, with bypass, gets one now).
  function automatic void model_commit(output bit v, output bit wen, output int dest,
                                       output logic [31:0] val);
    v = 1'b0; wen = 1'b0; dest = 0; val = '0;
    if (!flush && q.size() > 0) begin
      dest = q[0].dest;
      if (q[0].done) begin
        v = 1'b1;
        val = q[0].value;
      end else if (Byp && cdb_valid && int'(cdb_tag) == q[0].tag) begin
        v = 1'b1;
        val = cdb_value;
      end
      wen = v & q[0].wb;
    end
  endfunction

  task automatic compare();
    bit v, wen;
    int d;
    logic [31:0] val;
    if (rst_n) begin
      model_commit(v, wen, d, val);
      chk("m_alloc_ready", alloc_ready, q.size() != DEPTH);
      chk("m_alloc_tag", alloc_tag, tail_m);
      chk("m_count", count, q.size());
      chk("m_empty", empty, q.size() == 0);
      chk("m_commit_valid", commit_valid, v);
      chk("m_commit_wen", commit_wen, wen);
      if (v) begin
        chk("m_commit_dest", commit_dest, d);
        chk("m_commit_value", commit_value, val);
      end
    end
  endtask

  task automatic update();
    bit v, wen;
    int d, sz;
    logic [31:0] val;
    if (!rst_n || flush) begin
      q.delete();
      tail_m = 0;
      return;
    end
    model_commit(v, wen, d, val);
    sz = q.size();
    if (cdb_valid)
      foreach (q[k])
        if (q[k].tag == int'(cdb_tag) && !q[k].done) begin
          q[k].done  = 1'b1;
          q[k].value = cdb_value;
        end
    if (v) void'(q.pop_front());
    if (alloc_valid && sz != DEPTH) begin
      q.push_back(ent_t'{tag: tail_m, dest: int'(alloc_dest), wb: alloc_wb, done: 1'b0,
                         value: 32'h0});
      tail_m = (tail_m + 1) % DEPTH;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_dest = '0; alloc_wb = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; flush = 1'b0;
  endtask

  task automatic cdb(input int tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_tag = TAG_W'(tag); cdb_value = val;
  endtask

  task automatic alloc(input int dest, input bit wb);
    alloc_valid = 1'b1; alloc_dest = REG_W'(dest); alloc_wb = wb;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_wen", commit_wen, 0);
    chk("rst_commit_dest", commit_dest, 0);
    chk("rst_commit_value", commit_value, 0);

    for (int i = 0; i < 3; i++) begin
      alloc(i + 1, 1'b1); #1;
      chk("first_tags", alloc_tag, i);
      cyc();
    end
    idle(); #1;
    chk("count3", count, 3);
    chk("no_commit3", commit_valid, 0);

    // Out-of-order completion, in-order retire.
    cdb(2, 32'h33); cyc();
    cdb(0, 32'h11); #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("ooo_c1_dest", commit_dest, 1); chk("ooo_c1_val", commit_value, 32'h11);
`else
    chk("ooo_wait", commit_valid, 0);
`endif
    cyc();
    cdb(1, 32'h22); #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("ooo_c2_dest", commit_dest, 2); chk("ooo_c2_val", commit_value, 32'h22);
`else
    chk("ooo_c1_dest", commit_dest, 1); chk("ooo_c1_val", commit_value, 32'h11);
`endif
    chk("ooo_cv_a", commit_valid, 1);
    cyc();
    idle(); #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("ooo_c3_dest", commit_dest, 3); chk("ooo_c3_val", commit_value, 32'h33);
`else
    chk("ooo_c2_dest", commit_dest, 2); chk("ooo_c2_val", commit_value, 32'h22);
`endif
    chk("ooo_cv_b", commit_valid, 1);
    cyc();
    #1;
`ifndef ROB_CDB_BYPASS_EN
    chk("ooo_c3_dest", commit_dest, 3); chk("ooo_c3_val", commit_value, 32'h33);
`endif
    cyc();
    #1;
    chk("ooo_empty", empty, 1);

    // Fill across the wrap point: head = tail = 3 here.
    for (int i = 0; i < DEPTH; i++) begin
      alloc(8 + i, i != 0); #1;
      chk("fill_tag", alloc_tag, (3 + i) % DEPTH);
      cyc();
    end
    idle(); #1;
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 8);

    cdb(3, 32'h44); alloc(20, 1'b1); #1;
    chk("full_hold_ready", alloc_ready, 0);
`ifdef ROB_CDB_BYPASS_EN
    chk("byp_full_cv", commit_valid, 1);
    chk("byp_full_wen", commit_wen, 0);
    chk("byp_full_val", commit_value, 32'h44);
    cyc();
    cdb_valid = 1'b0; #1;
`else
    chk("full_cv0", commit_valid, 0);
    cyc();
    cdb_valid = 1'b0; #1;
    chk("full_cv", commit_valid, 1);
    chk("full_wen0", commit_wen, 0);
    chk("full_dest", commit_dest, 8);
    chk("full_ready_during_commit", alloc_ready, 0);
    cyc();
    #1;
`endif
    chk("refill_ready", alloc_ready, 1);
    chk("refill_count", count, 7);
    chk("refill_tag", alloc_tag, 3);
    cyc();
    idle(); #1;
    chk("refull_count", count, 8);
    chk("refull_tag", alloc_tag, 4);

    // Flush beside a head commit, a CDB hit and an allocation request.
    cdb(4, 32'h55); cyc();
    flush = 1'b1; cdb(Byp ? 5 : 6, 32'h66); alloc(21, 1'b1); #1;
    chk("flush_cv", commit_valid, 0);
    cyc();
    idle(); #1;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_tag", alloc_tag, 0);
    chk("flush_ready", alloc_ready, 1);

    // Head result latency and a no-writeback instruction.
    alloc(7, 1'b0); cyc();
    idle(); cdb(0, 32'hAA); #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("lat_cv", commit_valid, 1); chk("lat_val", commit_value, 32'hAA);
    chk("lat_wen", commit_wen, 0);
`else
    chk("lat_cv0", commit_valid, 0);
`endif
    cyc();
    idle(); #1;
`ifndef ROB_CDB_BYPASS_EN
    chk("lat_cv", commit_valid, 1); chk("lat_val", commit_value, 32'hAA);
    chk("lat_wen", commit_wen, 0); chk("lat_dest", commit_dest, 7);
`endif
    cyc();

    // Duplicate result to a DONE entry is dropped.
    alloc(4, 1'b1); cyc();
    alloc(5, 1'b1); cyc();
    idle(); cdb(2, 32'hBB); cyc();
    cdb(2, 32'hCC); cyc();
    cdb(1, 32'hDD); #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("dup_c1", commit_value, 32'hDD);
`endif
    cyc();
    idle(); #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("dup_c2_dest", commit_dest, 5); chk("dup_c2_val", commit_value, 32'hBB);
`else
    chk("dup_c1", commit_value, 32'hDD);
`endif
    cyc();
    #1;
`ifndef ROB_CDB_BYPASS_EN
    chk("dup_c2_dest", commit_dest, 5); chk("dup_c2_val", commit_value, 32'hBB);
`endif
    cyc();
    cyc();

    // Streaming: allocate every cycle, complete two cycles behind.
    for (int i = 0; i < 16; i++) begin
      alloc(i, i[0]);
      if (i >= 2) cdb((3 + i - 2) % DEPTH, 32'h100 + 32'(i));
      else cdb_valid = 1'b0;
      cyc();
    end
    idle();
    cdb((3 + 14) % DEPTH, 32'h200); cyc();
    cdb((3 + 15) % DEPTH, 32'h201); cyc();
    idle();
    for (int i = 0; i < 4; i++) cyc();
    #1;
    chk("stream_empty", empty, 1);

    // Reset in the middle of traffic.
    alloc(9, 1'b1); cyc(); cyc();
    idle(); rst_n = 1'b0; cyc();
    rst_n = 1'b1; #1;
    chk("midrst_empty", empty, 1);
    chk("midrst_tag", alloc_tag, 0);
    chk("midrst_cv", commit_valid, 0);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer_ring.md
# reorder_buffer_ring

Parametrised circular reorder buffer that holds `DEPTH` in-flight instructions. It allocates entries in program order from the instruction handler and captures results broadcast on the common data bus (CDB). It retires completed entries strictly in order, one per cycle, to the register file write port. The block sits between issue and register-file writeback and adds full/empty flow control, tag-based CDB capture and flush.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, at least 2.
- `XLEN`, 32: result value width.
- `REG_W`, 5: destination register index width.
- `TAG_W`, $clog2(DEPTH): entry tag width, derived.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `alloc_valid`  in  1  the handler presents an instruction.
- `alloc_ready`  out  1  an entry is free; equals `count != DEPTH`.
- `alloc_dest`  in  REG_W  destination register.
- `alloc_wb`  in  1  the instruction writes a register.
- `alloc_tag`  out  TAG_W  tag assigned on this allocation; equals `tail`.
- `cdb_valid`  in  1  CDB carries a result.
- `cdb_tag`  in  TAG_W  ROB tag of the result.
- `cdb_value`  in  XLEN  result value.
- `commit_valid`  out  1  the head entry retires this cycle.
- `commit_wen`  out  1  `commit_valid & wb` of the head entry.
- `commit_dest`  out  REG_W  destination register of the head entry.
- `commit_value`  out  XLEN  value of the head entry.
- `flush`  in  1  discard all entries.
- `count`  out  TAG_W+1  occupied entries.
- `empty`  out  1  `count == 0`.

## Operation
- Each entry has state IDLE, WAIT or DONE, plus dest, wb and value fields.
- Allocation fires on `alloc_valid & alloc_ready`:
  - The entry at `tail` goes IDLE→WAIT, latching `alloc_dest` and `alloc_wb`; value is cleared to 0.
  - `tail` increments modulo DEPTH.
- CDB capture fires on `cdb_valid` when the entry at `cdb_tag` is in WAIT:
  - The entry latches `cdb_value` and goes WAIT→DONE.
  - `cdb_valid` to an IDLE or DONE entry is ignored, with no state change.
- Commit: `commit_valid` = the head entry is DONE.
  - On commit, the head entry goes DONE→IDLE and `head` increments modulo DEPTH.
  - Commit needs no acknowledge; the register file always accepts.
- `count` next value = count + alloc_fire − commit_fire. A simultaneous allocation and commit leave `count` unchanged.
- When full, `alloc_ready` = 0 even if a commit happens in the same cycle; there is no same-cycle slot reuse.
- When empty, an entry allocated this cycle cannot commit before the next cycle.
- `flush` has priority over allocation, capture and commit in the same cycle:
  - All entries go IDLE; head = tail = count = 0.
  - `commit_valid` is forced to 0 during the flush cycle.
- Pointer wrap-around: head and tail are TAG_W bits; full versus empty is resolved by `count` only.

## Timing
- Reset (rst_n low at a clock edge):
  - head = tail = count = 0; all entries IDLE with cleared fields.
  - Outputs: `alloc_ready`=1, `alloc_tag`=0, `empty`=1, `commit_valid`=0, `commit_wen`=0, `commit_dest`=0, `commit_value`=0.
- A reset asserted mid-operation discards all in-flight entries, the same as a flush.
- `alloc_ready`, `alloc_tag`, `count` and `empty` come from registers only.
- All commit outputs are combinational from head-entry registers, except under the bypass described in Configuration.
- Latency without bypass: the CDB result at the head lands at edge N, and the commit is presented in cycle N+1.
- Back-to-back commits sustain 1 per cycle.

## Configuration
- `ROB_CDB_BYPASS_EN` defined:
  - If `cdb_valid` targets the head entry while it is in WAIT, `commit_valid` = 1 in the same cycle and `commit_value` = `cdb_value`.
  - The entry goes directly WAIT→IDLE and `head` advances at that edge.
  - This adds a `cdb_value` → `commit_value` combinational path.
- Undefined:
  - Every result spends at least one cycle in DONE.
  - There is no combinational path from the CDB inputs to the commit outputs.

## Structure
- Package `rob_pkg`:
  - The entry-state enum (IDLE/WAIT/DONE).
  - The entry struct {state, dest, wb, value}.
  - Default width constants `ROB_XLEN`=32 and `ROB_REG_W`=5.
- Sub-module `rob_slot`:
  - One entry register with per-slot alloc/capture/commit/flush enables.
  - Instantiated DEPTH times in a generate loop.
- The top level holds the pointers, the counter and the head-select mux.

## Test plan
- Reset, then allocate 3 entries (dest 1,2,3) → tags 0,1,2 returned; `count`=3; `commit_valid`=0.
- Out-of-order CDB: tag 2 gets 0x33, tag 0 gets 0x11, then tag 1 gets 0x22 → commits occur in order as dest1/0x11, dest2/0x22, dest3/0x33 on consecutive cycles.
- Fill DEPTH=8 → `alloc_ready`=0. Hold `alloc_valid` while the head commits → no allocation that cycle; `alloc_ready`=1 next cycle. Continue past 8 allocations to check wrap to tag 0.
- An entry with `alloc_wb`=0 completes → `commit_valid`=1 and `commit_wen`=0.
- Assert `flush` together with a CDB hit and a head commit → nothing commits; next cycle `count`=0, `empty`=1, `alloc_tag`=0.
- Send a CDB result to the head entry in WAIT:
  - With `ROB_CDB_BYPASS_EN` → commit in the same cycle with the CDB value.
  - Without it → commit one cycle later.
  - A duplicate CDB result to a DONE tag → ignored.
